// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions, waits for load data when needed,
// and drives the register-file write port for one cycle per committed instruction.
module wb_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_rf_we,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_ld_type,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  wR,
    output logic [31:0] wD,
    output logic        we,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t        stateReg, stateNext;
    logic [CW-1:0] cntReg, cntNext;
    logic [4:0]    rdReg;
    logic          rfWeReg;
    logic [2:0]    ldTypeReg;
    logic [1:0]    addrLoReg;
    logic [4:0]    wRReg, wRNext;
    logic [31:0]   wDReg, wDNext;
    logic          weReg, weNext;
    logic          errReg, errNext;

    logic          accept, isLoad, ldBad, timeoutHit;
    logic [31:0]   srcData, loadData;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;

    assign in_ready   = (stateReg != WAIT_MEM);
    assign busy       = (stateReg != IDLE);
    assign accept     = in_valid && in_ready;
    assign isLoad     = (in_wb_sel == 2'b01);
    assign timeoutHit = (cntReg == CW'(TIMEOUT - 1));
    assign wR         = wRReg;
    assign wD         = wDReg;
    assign we         = weReg;
    assign err        = errReg;

    // Illegal load types and misaligned halves/words are trapped at accept time.
    always_comb begin
        case (in_ld_type)
            3'b000, 3'b100: ldBad = 1'b0;
            3'b001, 3'b101: ldBad = in_addr_lo[0];
            3'b010:         ldBad = (in_addr_lo != 2'b00);
            default:        ldBad = 1'b1;
        endcase
    end

    always_comb begin
        case (in_wb_sel)
            2'b00:   srcData = in_alu;
            2'b10:   srcData = in_pc + 32'd4;
            2'b11:   srcData = in_imm;
            default: srcData = 32'h0;
        endcase
    end

    always_comb begin
        case (addrLoReg)
            2'd0:    byteSel = mem_rdata[7:0];
            2'd1:    byteSel = mem_rdata[15:8];
            2'd2:    byteSel = mem_rdata[23:16];
            default: byteSel = mem_rdata[31:24];
        endcase
        halfSel = addrLoReg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ldTypeReg)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b100:  loadData = {24'h0, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b101:  loadData = {16'h0, halfSel};
            default: loadData = mem_rdata;
        endcase
    end

    // State register plus the registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            cntReg    <= '0;
            rdReg     <= '0;
            rfWeReg   <= 1'b0;
            ldTypeReg <= '0;
            addrLoReg <= '0;
            wRReg     <= '0;
            wDReg     <= '0;
            weReg     <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            wRReg    <= wRNext;
            wDReg    <= wDNext;
            weReg    <= weNext;
            errReg   <= errNext;
            if (accept) begin
                rdReg     <= in_rd;
                rfWeReg   <= in_rf_we;
                ldTypeReg <= in_ld_type;
                addrLoReg <= in_addr_lo;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = '0;
        case (stateReg)
            WAIT_MEM: begin
                cntNext = cntReg + CW'(1);
                if (mem_rvalid)
                    stateNext = COMMIT;
                else if (timeoutHit)
                    stateNext = IDLE;
            end
            default: begin
                if (accept)
                    stateNext = (isLoad && !ldBad) ? WAIT_MEM : COMMIT;
                else
                    stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        weNext  = 1'b0;
        wRNext  = wRReg;
        wDNext  = wDReg;
        errNext = errReg;
        if (stateReg == WAIT_MEM) begin
            if (mem_rvalid) begin
                weNext = rfWeReg && (rdReg != 5'd0);
                wRNext = rdReg;
                wDNext = loadData;
            end else if (timeoutHit) begin
                errNext = 1'b1;
            end
        end else if (accept) begin
            if (!isLoad) begin
                weNext = in_rf_we && (in_rd != 5'd0);
                wRNext = in_rd;
                wDNext = srcData;
            end else if (ldBad) begin
                errNext = 1'b1;
                wRNext  = in_rd;
                wDNext  = 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand-written corner sequences,
// then random transactions checked against a transaction-level reference model.
module tb_wb_stage;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_rf_we = 1'b0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu = '0, in_pc = '0, in_imm = '0;
    logic [2:0]  in_ld_type = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic        we, busy, err;

    int nChecks = 0;
    int nFail = 0;

    wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rf_we(in_rf_we), .in_wb_sel(in_wb_sel),
        .in_alu(in_alu), .in_pc(in_pc), .in_imm(in_imm),
        .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wR(wR), .wD(wD), .we(we), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        rfWe;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  ldt;
        logic [1:0]  alo;
        logic [31:0] rdata;
        int          delay;   // idle WAIT_MEM cycles before the response; >= TO means none
        logic        gap;
        logic        expWe;
        logic [4:0]  expWR;
        logic [31:0] expWD;
        logic        expErr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ldLegal(input logic [2:0] ldt, input logic [1:0] alo);
        case (ldt)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (alo % 2) == 0;
            3'd2:       return alo == 0;
            default:    return 1'b0;
        endcase
    endfunction

    // Reference write data computed with plain shifts and modular arithmetic.
    function automatic logic [31:0] refData(input vec_t v);
        int unsigned b, h;
        b = (v.rdata >> (8 * int'(v.alo))) % 256;
        h = (v.rdata >> (16 * (int'(v.alo) / 2))) % 65536;
        case (v.sel)
            2'd0: return v.alu;
            2'd2: return v.pc + 32'd4;
            2'd3: return v.imm;
            default: begin
                case (v.ldt)
                    3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
                    3'd4:    return b;
                    3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
                    3'd5:    return h;
                    3'd2:    return v.rdata;
                    default: return 32'h0;
                endcase
            end
        endcase
    endfunction

    task automatic scramble();
        in_rd      = 5'($urandom);
        in_rf_we   = 1'($urandom);
        in_wb_sel  = 2'($urandom);
        in_alu     = $urandom;
        in_pc      = $urandom;
        in_imm     = $urandom;
        in_ld_type = 3'($urandom);
        in_addr_lo = 2'($urandom);
    endtask

    task automatic doTxn(input vec_t v);
        logic waits;
        waits = (v.sel == 2'b01) && ldLegal(v.ldt, v.alo);
        in_valid   = 1'b1;
        in_rd      = v.rd;
        in_rf_we   = v.rfWe;
        in_wb_sel  = v.sel;
        in_alu     = v.alu;
        in_pc      = v.pc;
        in_imm     = v.imm;
        in_ld_type = v.ldt;
        in_addr_lo = v.alo;
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        scramble();
        if (waits) begin
            check("wait_ready", 32'(in_ready), 32'd0);
            check("wait_we", 32'(we), 32'd0);
            if (v.delay >= TO) begin
                repeat (TO - 1) tick();
                check("to_busy_last", 32'(busy), 32'd1);
                tick();
                check("to_busy", 32'(busy), 32'd0);
                check("to_we", 32'(we), 32'd0);
                check("to_ready", 32'(in_ready), 32'd1);
            end else begin
                for (int i = 0; i < v.delay; i++) begin
                    tick();
                    check("wait_ready_n", 32'(in_ready), 32'd0);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
        if (!(waits && v.delay >= TO)) begin
            check("commit_we", 32'(we), 32'(v.expWe));
            check("commit_busy", 32'(busy), 32'd1);
            check("commit_ready", 32'(in_ready), 32'd1);
            if (v.expWe) begin
                check("commit_wR", 32'(wR), 32'(v.expWR));
                check("commit_wD", wD, v.expWD);
            end
        end
        check("err", 32'(err), 32'(v.expErr));
        if (v.gap) begin
            tick();
            check("gap_we", 32'(we), 32'd0);
            check("gap_busy", 32'(busy), 32'd0);
        end
    endtask

    vec_t tbl[14];
    vec_t rv;
    logic errModel;
    logic bad, tmo;

    initial begin
        //           sel    rd     we    alu           pc            imm           ldt   alo   rdata         dly gap  eWe  eWR    eWD           eErr
        tbl[0]  = '{2'b00, 5'd5,  1'b1, 32'h12345678, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        0,  1'b1, 1'b1, 5'd5,  32'h12345678, 1'b0};
        tbl[1]  = '{2'b10, 5'd1,  1'b1, 32'h0,        32'h00000100, 32'h0,        3'd0, 2'd0, 32'h0,        0,  1'b0, 1'b1, 5'd1,  32'h00000104, 1'b0};
        tbl[2]  = '{2'b10, 5'd2,  1'b1, 32'h0,        32'h00000104, 32'h0,        3'd0, 2'd0, 32'h0,        0,  1'b0, 1'b1, 5'd2,  32'h00000108, 1'b0};
        tbl[3]  = '{2'b10, 5'd3,  1'b1, 32'h0,        32'hFFFFFFFC, 32'h0,        3'd0, 2'd0, 32'h0,        0,  1'b0, 1'b1, 5'd3,  32'h00000000, 1'b0};
        tbl[4]  = '{2'b00, 5'd11, 1'b1, 32'h0BADF00D, 32'h0,        32'h0,        3'd7, 2'd3, 32'h0,        0,  1'b0, 1'b1, 5'd11, 32'h0BADF00D, 1'b0};
        tbl[5]  = '{2'b01, 5'd4,  1'b1, 32'h0,        32'h0,        32'h0,        3'd0, 2'd2, 32'h00800000, 4,  1'b0, 1'b1, 5'd4,  32'hFFFFFF80, 1'b0};
        tbl[6]  = '{2'b01, 5'd4,  1'b1, 32'h0,        32'h0,        32'h0,        3'd4, 2'd2, 32'h00800000, 4,  1'b0, 1'b1, 5'd4,  32'h00000080, 1'b0};
        tbl[7]  = '{2'b01, 5'd6,  1'b1, 32'h0,        32'h0,        32'h0,        3'd2, 2'd0, 32'hDEADBEEF, TO-1, 1'b0, 1'b1, 5'd6, 32'hDEADBEEF, 1'b0};
        tbl[8]  = '{2'b01, 5'd8,  1'b1, 32'h0,        32'h0,        32'h0,        3'd5, 2'd2, 32'h80011234, 0,  1'b0, 1'b1, 5'd8,  32'h00008001, 1'b0};
        tbl[9]  = '{2'b11, 5'd13, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 3'd0, 2'd0, 32'h0,        0,  1'b0, 1'b0, 5'd13, 32'hCAFEF00D, 1'b0};
        tbl[10] = '{2'b01, 5'd9,  1'b1, 32'h0,        32'h0,        32'h0,        3'd1, 2'd1, 32'h0,        0,  1'b0, 1'b0, 5'd9,  32'h0,        1'b1};
        tbl[11] = '{2'b00, 5'd7,  1'b1, 32'h0000A5A5, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        0,  1'b0, 1'b1, 5'd7,  32'h0000A5A5, 1'b1};
        tbl[12] = '{2'b11, 5'd10, 1'b1, 32'h0,        32'h0,        32'hCAFEF00D, 3'd0, 2'd0, 32'h0,        0,  1'b0, 1'b1, 5'd10, 32'hCAFEF00D, 1'b1};
        tbl[13] = '{2'b00, 5'd0,  1'b1, 32'h00000001, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(we), 32'd0);
        check("rst_wR", 32'(wR), 32'd0);
        check("rst_wD", wD, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) doTxn(tbl[i]);

        // Timeout with a late response that must be dropped.
        rv = '{2'b01, 5'd14, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0, 32'h11111111, TO, 1'b0, 1'b0, 5'd14, 32'h0, 1'b1};
        doTxn(rv);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h22222222;
        tick();
        mem_rvalid = 1'b0;
        check("late_we", 32'(we), 32'd0);
        check("late_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of WAIT_MEM.
        in_valid = 1'b1; in_wb_sel = 2'b01; in_ld_type = 3'd2; in_addr_lo = 2'd0;
        in_rd = 5'd12; in_rf_we = 1'b1;
        tick();
        in_valid = 1'b0;
        check("arst_pre_busy", 32'(busy), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_err", 32'(err), 32'd0);
        check("arst_wR", 32'(wR), 32'd0);
        check("arst_wD", wD, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h33333333;
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("arst_we", 32'(we), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        // Random transactions against the reference model.
        errModel = 1'b0;
        for (int n = 0; n < 300; n++) begin
            rv.sel   = 2'($urandom);
            rv.rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            rv.rfWe  = ($urandom_range(0, 7) != 0);
            rv.alu   = $urandom;
            rv.pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
            rv.imm   = $urandom;
            rv.rdata = $urandom;
            rv.alo   = 2'($urandom);
            rv.ldt   = 3'($urandom);
            if ($urandom_range(0, 19) != 0) begin
                case ($urandom_range(0, 4))
                    0: rv.ldt = 3'd0;
                    1: rv.ldt = 3'd4;
                    2: begin rv.ldt = 3'd1; rv.alo[0] = 1'b0; end
                    3: begin rv.ldt = 3'd5; rv.alo[0] = 1'b0; end
                    default: begin rv.ldt = 3'd2; rv.alo = 2'd0; end
                endcase
            end
            rv.delay = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, TO - 1));
            rv.gap   = ($urandom_range(0, 4) == 0);
            bad = (rv.sel == 2'b01) && !ldLegal(rv.ldt, rv.alo);
            tmo = (rv.sel == 2'b01) && !bad && (rv.delay >= TO);
            errModel = errModel | bad | tmo;
            rv.expWe  = !bad && !tmo && rv.rfWe && (rv.rd != 5'd0);
            rv.expWR  = rv.rd;
            rv.expWD  = refData(rv);
            rv.expErr = errModel;
            doTxn(rv);
        end

        tick();
        check("final_we", 32'(we), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
